somador_unit: RTL and testbench



---
 rtl/somador_pkg.sv | 9 +
 rtl/somador_fa.sv | 17 +
 rtl/somador_unit.sv | 77 +++++++
 tb/tb_somador_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/somador_pkg.sv
// somador_unit shared package: default operand width and data type.
// Build option SOMADOR_FLAGS_EN adds the cout/ovf flag outputs.
package somador_pkg;

  localparam int SOMADOR_WIDTH_DEF = 4;

  typedef logic [SOMADOR_WIDTH_DEF-1:0] somador_data_t;

endpackage

// File: rtl/somador_fa.sv
// somador_fa: 1-bit full adder cell of the ripple chain.
// Ports: a, b, cin in; s (sum), cout (carry) out.
module somador_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/somador_unit.sv
// somador_unit: registered WIDTH-bit ripple-carry adder, 1-cycle latency.
// Ports: clk, rst (sync, active-high), in_valid, ia, ib -> out, out_valid;
// cout/ovf exist only when SOMADOR_FLAGS_EN is defined.
module somador_unit
  import somador_pkg::*;
#(
  parameter int WIDTH = SOMADOR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ia,
  input  logic [WIDTH-1:0] ib,
  output logic [WIDTH-1:0] out,
`ifdef SOMADOR_FLAGS_EN
  output logic             cout,
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             valid_q;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    somador_fa u_fa (
      .a    (ia[i]),
      .b    (ib[i]),
      .cin  (c[i]),
      .s    (sum_d[i]),
      .cout (c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) sum_q <= sum_d;
    end
  end

  assign out       = sum_q;
  assign out_valid = valid_q;

`ifdef SOMADOR_FLAGS_EN
  logic cout_d, cout_q;
  logic ovf_d, ovf_q;

  // Carries into and out of the sign bit differ exactly on signed overflow.
  assign cout_d = c[WIDTH];
  assign ovf_d  = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (in_valid) begin
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cout = cout_q;
  assign ovf  = ovf_q;
`else
  logic carry_unused;
  assign carry_unused = ^c;
`endif

endmodule

// File: tb/tb_somador_unit.sv
// tb_somador_unit: directed + random stimulus for somador_unit,
// checked against an arithmetic reference model.
module tb_somador_unit;
  import somador_pkg::*;

  localparam int W = SOMADOR_WIDTH_DEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  somador_data_t ia, ib;
  somador_data_t out_w;
  logic          out_valid_w;
`ifdef SOMADOR_FLAGS_EN
  logic          cout_w, ovf_w;
`endif

  int total = 0;
  int bad   = 0;

  int m_out   = 0;
  int m_cout  = 0;
  int m_ovf   = 0;
  int m_valid = 0;

  always #5 clk = ~clk;

  somador_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .ia        (ia),
    .ib        (ib),
    .out       (out_w),
`ifdef SOMADOR_FLAGS_EN
    .cout      (cout_w),
    .ovf       (ovf_w),
`endif
    .out_valid (out_valid_w)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the sampled operands.
  task automatic model(input int r, input int v, input int a, input int b);
    int s, sa, sb, ss;
    if (r != 0) begin
      m_out = 0; m_cout = 0; m_ovf = 0; m_valid = 0;
    end else begin
      m_valid = v;
      if (v != 0) begin
        s  = a + b;
        sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
        ss = sa + sb;
        m_out  = s % (1 << W);
        m_cout = (s >= (1 << W)) ? 1 : 0;
        m_ovf  = (ss > (1 << (W-1)) - 1 || ss < -(1 << (W-1))) ? 1 : 0;
      end
    end
  endtask

  task automatic step(input string tag, input int r, input int v,
                      input int a, input int b);
    rst      = r[0];
    in_valid = v[0];
    ia       = somador_data_t'(a);
    ib       = somador_data_t'(b);
    @(posedge clk);
    #1;
    model(r, v, a, b);
    chk({tag, ".out"}, int'(out_w), m_out);
    chk({tag, ".vld"}, int'(out_valid_w), m_valid);
`ifdef SOMADOR_FLAGS_EN
    chk({tag, ".cout"}, int'(cout_w), m_cout);
    chk({tag, ".ovf"}, int'(ovf_w), m_ovf);
`endif
  endtask

  int da[9] = '{0, 2, 3, 10, 10, 10, 15, 7, 8};
  int db[9] = '{1, 1, 1, 1, 2, 3, 1, 1, 8};
  int dx[9] = '{1, 3, 4, 11, 12, 13, 0, 8, 0};

  initial begin
    rst = 1'b1; in_valid = 1'b0; ia = '0; ib = '0;

    step("rst0", 1, 1, 5, 5);
    step("rst1", 1, 1, 5, 5);

    // Directed sums; also pin the literal expected sums from the table.
    for (int i = 0; i < 9; i++) begin
      step($sformatf("dir%0d", i), 0, 1, da[i], db[i]);
      chk($sformatf("lit%0d", i), int'(out_w), dx[i]);
    end
`ifdef SOMADOR_FLAGS_EN
    chk("lit8.cout", int'(cout_w), 1);
    chk("lit8.ovf", int'(ovf_w), 1);
`endif

    step("ad3", 0, 1, 10, 3);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("hold%0d", i), 0, 0,
           int'($urandom_range(15)), int'($urandom_range(15)));
      chk($sformatf("holdD%0d", i), int'(out_w), 13);
    end

    step("rprio", 1, 1, 2, 2);
    step("rel", 0, 1, 2, 2);
    chk("rel.lit", int'(out_w), 4);

    for (int i = 0; i < 300; i++) begin
      step($sformatf("rnd%0d", i),
           ($urandom_range(19) == 0) ? 1 : 0,
           ($urandom_range(3) != 0) ? 1 : 0,
           int'($urandom_range(15)), int'($urandom_range(15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
